rng_extract: RTL and testbench
==============================

# rng_extract

Stream-to-range extractor: consumes an eot-terminated data stream on a DTI consumer port and emits, per transaction, the descriptor (base, incr, cnt) that describes it as an arithmetic progression, plus an error flag when the stream is not one. It is the inverse of the range generator. It sits at the output of generated-address/index streams in the cascade pipeline, where it compresses them back into range descriptors for checking and for re-injection into range generators.

## Interface
- W_DATA, 16, width of stream data, base and incr fields
- W_CNT, 16, width of beat counter / cnt field
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- din  dti.consumer  W_DATA+1  packed {eot, data[W_DATA-1:0]}, eot is the MSB
- dout  dti.producer  1+W_DATA+W_CNT+W_DATA  packed {err, incr, cnt, base}; base is at the LSBs, err is the MSB

## Operation
- FSM states:
  - FIRST: awaiting the transaction's first beat.
  - SECOND: awaiting the second beat.
  - RUN: awaiting later beats.
- FIRST, on a din handshake:
  - base_r <= data, prev_r <= data, cnt_r <= 1, err_r <= 0.
  - If eot=1: emit {0, incr=0, cnt=1, base=data} and stay in FIRST.
  - Otherwise go to SECOND.
- SECOND, on a handshake:
  - incr_r <= data - prev_r (modulo 2^W_DATA; two's-complement negative steps are natural).
  - prev_r <= data, cnt_r++.
  - If eot=1: emit and go to FIRST. Otherwise go to RUN.
- RUN, on a handshake:
  - If data != prev_r + incr_r (modulo 2^W_DATA), set err_r sticky.
  - prev_r <= data, cnt_r++.
  - If eot=1: emit and go to FIRST.
- Emit: load the output register with {err, incr, cnt (post-increment count incl. eot beat), base} and set dout.valid.
- cnt overflow: the counter saturates at 2^W_CNT-1 and sets err.
- All arithmetic is unsigned modulo its field width. There is no signed mode; the caller interprets incr.

## Timing
- Reset values:
  - dout.valid=0 and dout.data=0.
  - FSM=FIRST.
  - base_r, prev_r, incr_r, cnt_r and err_r are all 0.
- din.ready = !dout.valid | dout.ready. While the output register is free or draining, one beat is accepted per cycle.
- Latency: dout.valid rises in the cycle after the eot beat's handshake. This is 1 cycle, registered.
- dout.data is stable while dout.valid=1 and dout.ready=0.
- Simultaneous events:
  - If an eot handshake and a dout handshake fall in the same cycle, the register reloads and dout.valid stays 1.
  - A non-eot beat can be accepted while the previous descriptor is still pending only through the din.ready rule. The descriptor register is never overwritten before its handshake.
- dout.valid does not depend combinationally on din.valid.
- An asserted rst mid-transaction discards the partial transaction and any pending descriptor. The block restarts in FIRST.

## Configuration
- RNG_EXTRACT_CHECK_EN defined:
  - Progression compare in RUN is built.
  - Saturation sets err.
- RNG_EXTRACT_CHECK_EN undefined:
  - No compare logic is built; err is tied to 0.
  - The counter still saturates silently.
  - incr is taken from the first two beats only.

## Structure
- Package rng_extract_pkg holds:
  - the FSM state enum (FIRST/SECOND/RUN);
  - the din_t typedef {eot, data};
  - the dout_t typedef {err, incr, cnt, base}, parameterised through localparam widths of defaults.
- One sub-module, dti_out_reg: a single-entry DTI output register holding the valid/data pair, with ready pass-through giving din.ready.
- The FSM and datapath stay in the top module.
- Usage check: an initial assertion that $size(din.data)==W_DATA+1 and $size(dout.data)==2*W_DATA+W_CNT+1, with $fatal on mismatch.

## Test plan
- Stream 5,8,11,14(eot), dout.ready=1 -> one descriptor {err=0, incr=3, cnt=4, base=5}, valid 1 cycle after the eot beat.
- Single beat 42(eot) -> {err=0, incr=0, cnt=1, base=42}.
- Descending 10,7,4(eot), W_DATA=16 -> incr=16'hFFFD, cnt=3, base=10, err=0.
- Broken stream 0,2,4,7,8(eot) with CHECK_EN -> err=1, incr=2, cnt=5. Without CHECK_EN the same stream gives err=0.
- Back-pressure:
  - Stimulus: two back-to-back transactions 1,2(eot) then 9(eot), with dout.ready=0 for 5 cycles.
  - Required: din.ready drops while the first descriptor is pending, the second descriptor is not lost, and descriptors arrive in order {0,1,2,1} then {0,0,1,9}.
- Async rst asserted after beats 3,4 (no eot), then stream 6,6(eot) -> dout.valid=0 during reset and a single descriptor {0, incr=0, cnt=2, base=6}.

Source files
------------

// File: rtl/rng_extract_pkg.sv
// Shared types for rng_extract: FSM states and packed stream/descriptor layouts.
// Optional build macro: RNG_EXTRACT_CHECK_EN (progression/saturation error checking).
package rng_extract_pkg;

  localparam int unsigned DEF_W_DATA = 16;
  localparam int unsigned DEF_W_CNT  = 16;

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_SECOND,
    ST_RUN
  } state_e;

  // Input beat: eot is the MSB.
  typedef struct packed {
    logic                  eot;
    logic [DEF_W_DATA-1:0] data;
  } din_t;

  // Output descriptor: base at the LSBs, err at the MSB.
  typedef struct packed {
    logic                  err;
    logic [DEF_W_DATA-1:0] incr;
    logic [DEF_W_CNT-1:0]  cnt;
    logic [DEF_W_DATA-1:0] base;
  } dout_t;

  function automatic int unsigned dout_width(input int unsigned w_data, input int unsigned w_cnt);
    return 2 * w_data + w_cnt + 1;
  endfunction

endpackage

// File: rtl/rng_extract_dti_out_reg.sv
// Single-entry DTI output register. Upstream may load whenever the slot is
// empty or is being drained in the same cycle.
module dti_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_load_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_load_ready = !r_valid | i_ready;
  assign o_valid      = r_valid;
  assign o_data       = r_data;

  // Hold the descriptor until its handshake; a same-cycle load replaces it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rng_extract.sv
// rng_extract: compresses an eot-terminated stream into an arithmetic
// progression descriptor {err, incr, cnt, base}.
// Optional build macro: RNG_EXTRACT_CHECK_EN enables the progression compare
// and error on count saturation; otherwise err is constant 0.
module rng_extract
  import rng_extract_pkg::*;
#(
  parameter int unsigned W_DATA = DEF_W_DATA,
  parameter int unsigned W_CNT  = DEF_W_CNT
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_din_valid,
  output logic                                 o_din_ready,
  input  logic [W_DATA:0]                      i_din_data,
  output logic                                 o_dout_valid,
  input  logic                                 i_dout_ready,
  output logic [dout_width(W_DATA, W_CNT)-1:0] o_dout_data
);

  localparam int unsigned W_DOUT = dout_width(W_DATA, W_CNT);

  if (($bits(i_din_data) != W_DATA + 1) || ($bits(o_dout_data) != 2 * W_DATA + W_CNT + 1)) begin : g_bad_width
    $fatal(1, "rng_extract: port widths inconsistent with W_DATA/W_CNT");
  end

  state_e              r_state;
  logic [W_DATA-1:0]   r_base;
  logic [W_DATA-1:0]   r_prev;
  logic [W_DATA-1:0]   r_incr;
  logic [W_CNT-1:0]    r_cnt;
  logic                r_err;

  logic                w_ready;
  logic                w_hs;
  logic                w_eot;
  logic [W_DATA-1:0]   w_data;
  logic                w_cnt_sat;
  logic [W_CNT-1:0]    w_cnt_inc;
  logic [W_DATA-1:0]   w_step;
  logic                w_err_second;
  logic                w_err_run;
  logic                w_emit;
  logic [W_DOUT-1:0]   w_desc;

  assign o_din_ready = w_ready;
  assign w_hs        = i_din_valid & w_ready;

`ifdef RNG_EXTRACT_CHECK_EN
  logic [W_DATA-1:0] w_pred;
  assign w_pred = r_prev + r_incr;
`endif

  // Beat decode, next counter/error values and the descriptor to emit on eot.
  always_comb begin
    w_eot     = i_din_data[W_DATA];
    w_data    = i_din_data[W_DATA-1:0];
    w_cnt_sat = (r_cnt == '1);
    w_cnt_inc = w_cnt_sat ? r_cnt : r_cnt + W_CNT'(1);
    w_step    = w_data - r_prev;
`ifdef RNG_EXTRACT_CHECK_EN
    w_err_second = r_err | w_cnt_sat;
    w_err_run    = r_err | w_cnt_sat | (w_data != w_pred);
`else
    // r_err only ever reloads 0 here, so err stays tied low.
    w_err_second = r_err;
    w_err_run    = r_err;
`endif
    w_emit = 1'b0;
    w_desc = '0;
    if (w_hs && w_eot) begin
      w_emit = 1'b1;
      case (r_state)
        ST_FIRST:  w_desc = {1'b0, {W_DATA{1'b0}}, W_CNT'(1), w_data};
        ST_SECOND: w_desc = {w_err_second, w_step, w_cnt_inc, r_base};
        ST_RUN:    w_desc = {w_err_run, r_incr, w_cnt_inc, r_base};
        default:   w_desc = '0;
      endcase
    end
  end

  // Transaction FSM and progression tracking registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_FIRST;
      r_base  <= '0;
      r_prev  <= '0;
      r_incr  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_hs) begin
      case (r_state)
        ST_FIRST: begin
          r_base <= w_data;
          r_prev <= w_data;
          r_cnt  <= W_CNT'(1);
          r_err  <= 1'b0;
          if (!w_eot) r_state <= ST_SECOND;
        end
        ST_SECOND: begin
          r_incr  <= w_step;
          r_prev  <= w_data;
          r_cnt   <= w_cnt_inc;
          r_err   <= w_err_second;
          r_state <= w_eot ? ST_FIRST : ST_RUN;
        end
        ST_RUN: begin
          r_prev <= w_data;
          r_cnt  <= w_cnt_inc;
          r_err  <= w_err_run;
          if (w_eot) r_state <= ST_FIRST;
        end
        default: r_state <= ST_FIRST;
      endcase
    end
  end

  dti_out_reg #(
    .W (W_DOUT)
  ) u_out (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_emit),
    .i_data       (w_desc),
    .o_load_ready (w_ready),
    .o_valid      (o_dout_valid),
    .o_data       (o_dout_data),
    .i_ready      (i_dout_ready)
  );

endmodule

// File: tb/tb_rng_extract.sv
// Self-checking bench for rng_extract: directed cases plus random streams
// checked against a progression model built from the descriptor definition.
module tb_rng_extract;
  import rng_extract_pkg::*;

`ifdef RNG_EXTRACT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [16:0] din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [48:0] dout_data;

  rng_extract #(
    .W_DATA (16),
    .W_CNT  (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .i_din_data   (din_data),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_dout_data  (dout_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  dout_t       exp_q[$];
  logic [15:0] cur[$];
  int unsigned rdy_mode;   // 0 random, 1 always ready, 2 never ready
  bit          use_model;
  bit          stall_prev;
  logic [48:0] stall_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Descriptor of a finished stream: base is the first beat, incr the first
  // step, and the stream is clean when every beat equals base + i*incr.
  function automatic dout_t model(input logic [15:0] q[$]);
    dout_t       d;
    int unsigned n;
    bit          bad;
    n = q.size();
    bad = 1'b0;
    d.base = q[0];
    d.cnt  = (n > 65535) ? 16'hFFFF : 16'(n);
    d.incr = (n > 1) ? 16'(q[1] - q[0]) : 16'h0;
    for (int unsigned i = 2; i < n; i++)
      if (q[i] !== 16'(q[0] + 16'(i) * d.incr)) bad = 1'b1;
    d.err = CHK && (bad || n > 65535);
    return d;
  endfunction

  // Advance to the next falling edge, drive dout_ready, then observe outputs.
  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      1:       dout_ready = 1'b1;
      2:       dout_ready = 1'b0;
      default: dout_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    if (stall_prev) begin
      check("hold_valid", 64'(dout_valid), 64'd1);
      check("hold_data", 64'(dout_data), 64'(stall_data));
    end
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL desc_extra observed=%0h expected=none", dout_data);
      end else begin
        check("desc", 64'(dout_data), 64'(exp_q.pop_front()));
      end
    end
    stall_prev = dout_valid && !dout_ready;
    stall_data = dout_data;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic e, input int unsigned gap);
    int unsigned t;
    repeat (gap) begin
      tick();
      din_valid = 1'b0;
    end
    t = 0;
    forever begin
      tick();
      din_valid = 1'b1;
      din_data  = {e, d};
      if (din_ready) break;
      t++;
      if (t > 100) begin
        checks++;
        errors++;
        $error("FAIL din_timeout observed=0 expected=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    cur.push_back(d);
    if (e) begin
      if (use_model) exp_q.push_back(model(cur));
      cur.delete();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_data", 64'(dout_data), 64'd0);
    check("rst_din_ready", 64'(din_ready), 64'd1);
    exp_q.delete();
    cur.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    rdy_mode   = 1;
    use_model  = 1'b0;
    stall_prev = 1'b0;
    stall_data = '0;
    #2;
    check("reset_valid", 64'(dout_valid), 64'd0);
    check("reset_data", 64'(dout_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ascending progression, latency of one cycle after the eot beat.
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'd3, cnt: 16'd4, base: 16'd5});
    send_beat(16'd5, 1'b0, 0);
    send_beat(16'd8, 1'b0, 0);
    send_beat(16'd11, 1'b0, 0);
    check("pre_eot_valid", 64'(dout_valid), 64'd0);
    send_beat(16'd14, 1'b1, 0);
    check("latency_valid", 64'(dout_valid), 64'd1);
    drain();

    // Single-beat transaction.
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'd0, cnt: 16'd1, base: 16'd42});
    send_beat(16'd42, 1'b1, 1);
    drain();

    // Descending progression wraps modulo 2^16.
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'hFFFD, cnt: 16'd3, base: 16'd10});
    send_beat(16'd10, 1'b0, 0);
    send_beat(16'd7, 1'b0, 0);
    send_beat(16'd4, 1'b1, 0);
    drain();

    // Broken progression: err only in the checking build.
    exp_q.push_back(dout_t'{err: CHK, incr: 16'd2, cnt: 16'd5, base: 16'd0});
    send_beat(16'd0, 1'b0, 0);
    send_beat(16'd2, 1'b0, 0);
    send_beat(16'd4, 1'b0, 0);
    send_beat(16'd7, 1'b0, 0);
    send_beat(16'd8, 1'b1, 0);
    drain();

    // Back-pressure: second transaction waits, both arrive in order.
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'd1, cnt: 16'd2, base: 16'd1});
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'd0, cnt: 16'd1, base: 16'd9});
    rdy_mode = 2;
    send_beat(16'd1, 1'b0, 0);
    send_beat(16'd2, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      din_valid = 1'b1;
      din_data  = {1'b1, 16'd9};
      check("bp_din_ready", 64'(din_ready), 64'd0);
      check("bp_valid", 64'(dout_valid), 64'd1);
    end
    rdy_mode = 1;
    send_beat(16'd9, 1'b1, 0);
    check("bp_reload_valid", 64'(dout_valid), 64'd1);
    drain();

    // Reset mid-transaction discards the partial stream.
    send_beat(16'd3, 1'b0, 0);
    send_beat(16'd4, 1'b0, 0);
    do_reset();
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'd0, cnt: 16'd2, base: 16'd6});
    send_beat(16'd6, 1'b0, 0);
    send_beat(16'd6, 1'b1, 0);
    drain();

    // Reset also drops a pending descriptor.
    rdy_mode = 2;
    exp_q.push_back(dout_t'{err: 1'b0, incr: 16'd0, cnt: 16'd1, base: 16'd77});
    send_beat(16'd77, 1'b1, 0);
    check("pending_valid", 64'(dout_valid), 64'd1);
    do_reset();
    rdy_mode = 1;
    tick();
    check("post_rst_valid", 64'(dout_valid), 64'd0);

    // Random streams with random gaps and random output back-pressure.
    use_model = 1'b1;
    rdy_mode  = 0;
    for (int t = 0; t < 40; t++) begin
      int unsigned len;
      bit          prog;
      logic [15:0] b;
      logic [15:0] s;
      len  = $urandom_range(1, 6);
      prog = ($urandom_range(0, 1) == 1);
      b    = 16'($urandom);
      s    = 16'($urandom);
      for (int unsigned i = 0; i < len; i++) begin
        logic [15:0] v;
        v = prog ? 16'(b + 16'(i) * s) : 16'($urandom);
        send_beat(v, (i == len - 1), $urandom_range(0, 2));
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
